vx_ti_ray_dispatch: RTL and testbench
=====================================

# VX_ti_ray_dispatch

Initiator side of the triangle-intersection datapath. Accepts one ray job (origin, direction, t_max, contiguous triangle range), fetches each triangle's three vertices from triangle memory, issues ray/triangle pairs to the pipelined intersection unit, and reduces the returned hits to the single closest hit. The result goes back to the requesting traversal/core logic over a valid/ready response.

## Interface
- FLOAT_BITS, `TI_FLOAT_BITS (32): scalar float width; a vec3 is 3*FLOAT_BITS, packed as X [31:0], Y [63:32], Z [95:64].
- IDX_BITS, 16: triangle index width.
- MAX_OUTSTANDING, 4: triangles in flight, counted from mem request to intersect response; must be ≥1.

Ports. One clock; reset is asynchronous and active-high.
- clk  in  1  clock
- reset  in  1  async active-high reset
- req_valid / req_ready  in / out  1  ray job handshake
- req_origin, req_dir  in  96  ray vec3
- req_tmax  in  32  initial max distance, positive float
- req_tri_base  in  IDX_BITS  first triangle index
- req_tri_count  in  IDX_BITS+1  number of triangles, 0 allowed
- mem_req_valid / mem_req_ready  out / in  1  vertex fetch handshake
- mem_req_idx  out  IDX_BITS  triangle index
- mem_rsp_valid / mem_rsp_ready  in / out  1  vertex return, in order
- mem_rsp_verts  in  288  v0 [95:0], v1 [191:96], v2 [287:192]
- isect_req_valid / isect_req_ready  out / in  1  intersect issue
- isect_req_verts  out  288  mem_rsp_verts passthrough
- isect_req_origin, isect_req_dir  out  96  latched ray
- isect_req_tmax  out  32  current best t
- isect_req_tag  out  IDX_BITS  triangle index
- isect_rsp_valid  in  1  intersect result, in order
- isect_rsp_ready  out  1  accept result
- isect_rsp_hit  in  1  hit flag
- isect_rsp_u, isect_rsp_v, isect_rsp_t  in  32  barycentrics and distance
- isect_rsp_tag  in  IDX_BITS  triangle index
- rsp_valid / rsp_ready  out / in  1  result handshake
- rsp_hit  out  1  any hit found
- rsp_tri_idx  out  IDX_BITS  closest triangle index
- rsp_t, rsp_u, rsp_v  out  32  closest hit values

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: req_ready=1. On accept, latch the ray. Load best_t=req_tmax, best_hit=0, best_idx=0, best_u=best_v=0, issue_idx=req_tri_base, issue_left=req_tri_count, ret_left=req_tri_count. If count==0, go to DONE; otherwise go to RUN.
- RUN, fetch: mem_req_valid = (issue_left≠0) && (credits<MAX_OUTSTANDING). On a mem handshake: credits++, issue_idx++, issue_left--.
- RUN, forward: isect_req_valid=mem_rsp_valid, mem_rsp_ready=isect_req_ready (combinational passthrough). isect_req_tag comes from a forward counter fwd_idx, initialised to req_tri_base, incremented on each isect handshake.
- RUN, collect: isect_rsp_ready=1. On each response: credits--, ret_left--. Update the best record iff hit && t_bits < best_t_bits. The compare is an unsigned integer compare, valid because both values are positive floats. The compare is strict, so the lower index wins a tie. Always re-compare, because isect_req_tmax may be stale for triangles already in flight.
- Simultaneous issue and return in one cycle: credits is unchanged.
- ret_left reaching 0 → DONE.
- DONE: rsp_valid=1, with outputs driven from the best record. Hold until rsp_ready, then go to IDLE. A new req is not accepted in the same cycle as the DONE handshake.
- An isect_rsp_valid outside RUN is a protocol error: assertion only, no state change.

## Timing
- Reset (any cycle, including mid-job): state=IDLE and all counters 0. Every valid output and rsp_* is 0; req_ready=1 one cycle after reset deasserts. In-flight responses after reset are the system's responsibility to flush.
- First mem_req_valid: the cycle after the req accept.
- mem→isect path: zero added latency.
- rsp_valid: the cycle after the final isect response.
- count==0: rsp_valid the cycle after accept, with rsp_hit=0 and rsp_t=req_tmax.
- Sustained throughput: 1 triangle/cycle when memory and intersect latency ≤ MAX_OUTSTANDING cycles.

## Structure
- VX_ti_pkg holds:
  - ti_vec3_t
  - ti_tri_t (3× vec3)
  - ti_hit_t {hit, idx, t, u, v}
  - dispatch state enum
  - vec3 bit-range localparams
- Sub-module VX_ti_hit_reduce: best-hit register plus unsigned compare, with load/update ports.
- credits width is $clog2(MAX_OUTSTANDING+1).

## Test plan
- Single triangle. Job count=1, tmax=100.0 (0x42C80000); isect returns hit with t=2.0 (0x40000000) → rsp_hit=1, rsp_t=0x40000000, rsp_tri_idx=base.
- Closest selection. Base=10, count=3; t=5.0, 1.0, 2.0, all hits → rsp_tri_idx=11, rsp_t=0x3F800000; u/v are those of idx 11.
- Tie. Two hits with identical t=1.0 at idx 4 and 5 → rsp_tri_idx=4.
- No hit. count=3, all isect_rsp_hit=0 → rsp_hit=0, rsp_t=0x42C80000.
- Credit limit. MAX_OUTSTANDING=4, count=8, isect_req_ready held 0 → exactly 4 mem requests issued, then mem_req_valid stays 0. After release, all 8 triangles complete.
- Zero count and reset. count=0 → rsp_valid next cycle, rsp_hit=0. Separately, assert reset mid-RUN → next cycle all valids are 0 and req_ready=1.

Source files
------------

// File: rtl/vx_ti_pkg.sv
// Shared types and constants for the triangle-intersection datapath.
// Contents: vec3 / triangle / hit-record types, vec3 bit-range constants,
// dispatch FSM state encoding, and the closest-hit distance compare.
package vx_ti_pkg;

    localparam int TI_FLOAT_BITS = 32;
    localparam int TI_IDX_BITS   = 16;
    localparam int TI_VEC3_BITS  = 3 * TI_FLOAT_BITS;
    localparam int TI_TRI_BITS   = 3 * TI_VEC3_BITS;

    // Component placement inside a packed vec3.
    localparam int VEC3_X_LSB = 0;
    localparam int VEC3_Y_LSB = TI_FLOAT_BITS;
    localparam int VEC3_Z_LSB = 2 * TI_FLOAT_BITS;

    typedef logic [TI_VEC3_BITS-1:0] ti_vec3_t;

    // v0 occupies the low bits, v2 the high bits.
    typedef struct packed {
        ti_vec3_t v2;
        ti_vec3_t v1;
        ti_vec3_t v0;
    } ti_tri_t;

    typedef struct packed {
        logic                     hit;
        logic [TI_IDX_BITS-1:0]   idx;
        logic [TI_FLOAT_BITS-1:0] t;
        logic [TI_FLOAT_BITS-1:0] u;
        logic [TI_FLOAT_BITS-1:0] v;
    } ti_hit_t;

    typedef enum logic [1:0] {
        DISPATCH_IDLE = 2'd0,
        DISPATCH_RUN  = 2'd1,
        DISPATCH_DONE = 2'd2
    } dispatch_state_e;

    // Both distances are positive IEEE floats, so their bit patterns order
    // the same way as the values. Strict: an equal distance never replaces.
    function automatic logic ti_t_closer(input logic [TI_FLOAT_BITS-1:0] cand_t,
                                         input logic [TI_FLOAT_BITS-1:0] best_t);
        return (cand_t < best_t);
    endfunction

endpackage

// File: rtl/vx_ti_hit_reduce.sv
// Closest-hit register.
//   load_i   : clear the record and seed best t with load_t_i (job start)
//   update_i : candidate result present; replaces the record when it is a
//              hit strictly closer than the current best
//   best_o   : current best record
module vx_ti_hit_reduce
    import vx_ti_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_i,
    input  logic [TI_FLOAT_BITS-1:0] load_t_i,
    input  logic                     update_i,
    input  ti_hit_t                  cand_i,
    output ti_hit_t                  best_o
);

    ti_hit_t best_q;
    ti_hit_t best_d;

    // Next best record: seed on load, replace on a strictly closer hit.
    always_comb begin
        best_d = best_q;
        if (load_i) begin
            best_d   = '0;
            best_d.t = load_t_i;
        end else if (update_i && cand_i.hit && ti_t_closer(cand_i.t, best_q.t)) begin
            best_d = cand_i;
        end else begin
            best_d = best_q;
        end
    end

    // Best record storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            best_q <= '0;
        end else begin
            best_q <= best_d;
        end
    end

    assign best_o = best_q;

endmodule

// File: rtl/vx_ti_ray_dispatch_chk.sv
// Protocol checks for the ray dispatcher.
//   run_i             : dispatcher is in its RUN state
//   isect_rsp_valid_i : intersect result presented
//   credits_i         : triangles currently in flight
module vx_ti_ray_dispatch_chk #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CW              = 3
) (
    input logic          clk,
    input logic          reset,
    input logic          run_i,
    input logic          isect_rsp_valid_i,
    input logic [CW-1:0] credits_i
);

    // Intersect results are only legal while a job is running.
    a_rsp_in_run: assert property (@(posedge clk) disable iff (reset)
        isect_rsp_valid_i |-> run_i);

    // In-flight count never exceeds the credit pool.
    a_credit_bound: assert property (@(posedge clk) disable iff (reset)
        credits_i <= CW'(MAX_OUTSTANDING));

endmodule

// File: rtl/vx_ti_ray_dispatch.sv
// Triangle-intersection initiator. Accepts one ray job, fetches each
// triangle of a contiguous range from vertex memory, forwards vertices with
// the ray to the intersect unit, and returns the closest hit.
// Ports:
//   req_*   : ray job in (origin, dir, t_max, triangle base/count)
//   mem_req_* / mem_rsp_* : vertex fetch (in-order returns)
//   isect_req_* / isect_rsp_* : intersect issue and in-order results
//   rsp_*   : closest-hit result out
module vx_ti_ray_dispatch
    import vx_ti_pkg::*;
#(
    parameter int FLOAT_BITS      = TI_FLOAT_BITS,
    parameter int IDX_BITS        = TI_IDX_BITS,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [3*FLOAT_BITS-1:0] req_origin,
    input  logic [3*FLOAT_BITS-1:0] req_dir,
    input  logic [FLOAT_BITS-1:0]   req_tmax,
    input  logic [IDX_BITS-1:0]     req_tri_base,
    input  logic [IDX_BITS:0]       req_tri_count,

    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [IDX_BITS-1:0]     mem_req_idx,
    input  logic                    mem_rsp_valid,
    output logic                    mem_rsp_ready,
    input  logic [9*FLOAT_BITS-1:0] mem_rsp_verts,

    output logic                    isect_req_valid,
    input  logic                    isect_req_ready,
    output logic [9*FLOAT_BITS-1:0] isect_req_verts,
    output logic [3*FLOAT_BITS-1:0] isect_req_origin,
    output logic [3*FLOAT_BITS-1:0] isect_req_dir,
    output logic [FLOAT_BITS-1:0]   isect_req_tmax,
    output logic [IDX_BITS-1:0]     isect_req_tag,
    input  logic                    isect_rsp_valid,
    output logic                    isect_rsp_ready,
    input  logic                    isect_rsp_hit,
    input  logic [FLOAT_BITS-1:0]   isect_rsp_u,
    input  logic [FLOAT_BITS-1:0]   isect_rsp_v,
    input  logic [FLOAT_BITS-1:0]   isect_rsp_t,
    input  logic [IDX_BITS-1:0]     isect_rsp_tag,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_hit,
    output logic [IDX_BITS-1:0]     rsp_tri_idx,
    output logic [FLOAT_BITS-1:0]   rsp_t,
    output logic [FLOAT_BITS-1:0]   rsp_u,
    output logic [FLOAT_BITS-1:0]   rsp_v
);

    localparam int CW       = $clog2(MAX_OUTSTANDING + 1);
    localparam int CNT_BITS = IDX_BITS + 1;
    localparam logic [CW-1:0] MAX_CRED = CW'(MAX_OUTSTANDING);

    dispatch_state_e           state_q, state_d;
    logic [CW-1:0]             credits_q, credits_d;
    logic [IDX_BITS-1:0]       issue_idx_q, issue_idx_d;
    logic [CNT_BITS-1:0]       issue_left_q, issue_left_d;
    logic [CNT_BITS-1:0]       ret_left_q, ret_left_d;
    logic [IDX_BITS-1:0]       fwd_idx_q, fwd_idx_d;
    logic [3*FLOAT_BITS-1:0]   origin_q, origin_d;
    logic [3*FLOAT_BITS-1:0]   dir_q, dir_d;

    logic    run_s;
    logic    accept_s;
    logic    mem_fire_s;
    logic    fwd_fire_s;
    logic    ret_fire_s;
    ti_hit_t cand_s;
    ti_hit_t best_s;

    assign run_s      = (state_q == DISPATCH_RUN);
    assign accept_s   = (state_q == DISPATCH_IDLE) && req_valid;
    assign mem_fire_s = mem_req_valid && mem_req_ready;
    assign fwd_fire_s = isect_req_valid && isect_req_ready;
    assign ret_fire_s = isect_rsp_valid && isect_rsp_ready;

    // Handshake outputs decode registered state; the vertex path is a
    // zero-latency passthrough gated to RUN.
    assign req_ready        = (state_q == DISPATCH_IDLE);
    assign mem_req_valid    = run_s && (issue_left_q != '0) && (credits_q < MAX_CRED);
    assign mem_req_idx      = issue_idx_q;
    assign isect_req_valid  = run_s && mem_rsp_valid;
    assign mem_rsp_ready    = run_s && isect_req_ready;
    assign isect_req_verts  = mem_rsp_verts;
    assign isect_req_origin = origin_q;
    assign isect_req_dir    = dir_q;
    assign isect_req_tmax   = best_s.t;
    assign isect_req_tag    = fwd_idx_q;
    assign isect_rsp_ready  = run_s;

    assign rsp_valid   = (state_q == DISPATCH_DONE);
    assign rsp_hit     = best_s.hit;
    assign rsp_tri_idx = best_s.idx;
    assign rsp_t       = best_s.t;
    assign rsp_u       = best_s.u;
    assign rsp_v       = best_s.v;

    assign cand_s.hit = isect_rsp_hit;
    assign cand_s.idx = isect_rsp_tag;
    assign cand_s.t   = isect_rsp_t;
    assign cand_s.u   = isect_rsp_u;
    assign cand_s.v   = isect_rsp_v;

    // Next-state and counter updates for the job sequencer.
    always_comb begin
        state_d      = state_q;
        credits_d    = credits_q;
        issue_idx_d  = issue_idx_q;
        issue_left_d = issue_left_q;
        ret_left_d   = ret_left_q;
        fwd_idx_d    = fwd_idx_q;
        origin_d     = origin_q;
        dir_d        = dir_q;
        case (state_q)
            DISPATCH_IDLE: begin
                if (req_valid) begin
                    origin_d     = req_origin;
                    dir_d        = req_dir;
                    credits_d    = '0;
                    issue_idx_d  = req_tri_base;
                    fwd_idx_d    = req_tri_base;
                    issue_left_d = req_tri_count;
                    ret_left_d   = req_tri_count;
                    if (req_tri_count == '0) begin
                        state_d = DISPATCH_DONE;
                    end else begin
                        state_d = DISPATCH_RUN;
                    end
                end else begin
                    state_d = DISPATCH_IDLE;
                end
            end
            DISPATCH_RUN: begin
                if (mem_fire_s) begin
                    issue_idx_d  = issue_idx_q + IDX_BITS'(1);
                    issue_left_d = issue_left_q - CNT_BITS'(1);
                end else begin
                    issue_idx_d  = issue_idx_q;
                    issue_left_d = issue_left_q;
                end
                if (fwd_fire_s) begin
                    fwd_idx_d = fwd_idx_q + IDX_BITS'(1);
                end else begin
                    fwd_idx_d = fwd_idx_q;
                end
                // An issue and a return in the same cycle cancel out.
                case ({mem_fire_s, ret_fire_s})
                    2'b10:   credits_d = credits_q + CW'(1);
                    2'b01:   credits_d = credits_q - CW'(1);
                    default: credits_d = credits_q;
                endcase
                if (ret_fire_s) begin
                    ret_left_d = ret_left_q - CNT_BITS'(1);
                    if (ret_left_q == CNT_BITS'(1)) begin
                        state_d = DISPATCH_DONE;
                    end else begin
                        state_d = DISPATCH_RUN;
                    end
                end else begin
                    ret_left_d = ret_left_q;
                end
            end
            DISPATCH_DONE: begin
                if (rsp_ready) begin
                    state_d = DISPATCH_IDLE;
                end else begin
                    state_d = DISPATCH_DONE;
                end
            end
            default: begin
                state_d = DISPATCH_IDLE;
            end
        endcase
    end

    // Sequencer state and latched ray.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= DISPATCH_IDLE;
            credits_q    <= '0;
            issue_idx_q  <= '0;
            issue_left_q <= '0;
            ret_left_q   <= '0;
            fwd_idx_q    <= '0;
            origin_q     <= '0;
            dir_q        <= '0;
        end else begin
            state_q      <= state_d;
            credits_q    <= credits_d;
            issue_idx_q  <= issue_idx_d;
            issue_left_q <= issue_left_d;
            ret_left_q   <= ret_left_d;
            fwd_idx_q    <= fwd_idx_d;
            origin_q     <= origin_d;
            dir_q        <= dir_d;
        end
    end

    vx_ti_hit_reduce u_reduce (
        .clk      (clk),
        .reset    (reset),
        .load_i   (accept_s),
        .load_t_i (req_tmax),
        .update_i (ret_fire_s),
        .cand_i   (cand_s),
        .best_o   (best_s)
    );

    vx_ti_ray_dispatch_chk #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CW              (CW)
    ) u_chk (
        .clk               (clk),
        .reset             (reset),
        .run_i             (run_s),
        .isect_rsp_valid_i (isect_rsp_valid),
        .credits_i         (credits_q)
    );

endmodule

// File: tb/tb_vx_ti_ray_dispatch.sv
// Bench for vx_ti_ray_dispatch: in-order memory and intersect models,
// a table of ray jobs with hand-derived closest-hit results, and
// hand-written credit-limit and mid-job reset sequences.
module tb_vx_ti_ray_dispatch;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid, req_ready;
    logic [95:0]  req_origin, req_dir;
    logic [31:0]  req_tmax;
    logic [15:0]  req_tri_base;
    logic [16:0]  req_tri_count;
    logic         mem_req_valid, mem_req_ready;
    logic [15:0]  mem_req_idx;
    logic         mem_rsp_valid, mem_rsp_ready;
    logic [287:0] mem_rsp_verts;
    logic         isect_req_valid, isect_req_ready;
    logic [287:0] isect_req_verts;
    logic [95:0]  isect_req_origin, isect_req_dir;
    logic [31:0]  isect_req_tmax;
    logic [15:0]  isect_req_tag;
    logic         isect_rsp_valid, isect_rsp_ready, isect_rsp_hit;
    logic [31:0]  isect_rsp_u, isect_rsp_v, isect_rsp_t;
    logic [15:0]  isect_rsp_tag;
    logic         rsp_valid, rsp_ready, rsp_hit;
    logic [15:0]  rsp_tri_idx;
    logic [31:0]  rsp_t, rsp_u, rsp_v;

    always #5 clk = ~clk;

    vx_ti_ray_dispatch dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_origin(req_origin), .req_dir(req_dir), .req_tmax(req_tmax),
        .req_tri_base(req_tri_base), .req_tri_count(req_tri_count),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_idx(mem_req_idx),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rsp_verts(mem_rsp_verts),
        .isect_req_valid(isect_req_valid), .isect_req_ready(isect_req_ready),
        .isect_req_verts(isect_req_verts), .isect_req_origin(isect_req_origin),
        .isect_req_dir(isect_req_dir), .isect_req_tmax(isect_req_tmax),
        .isect_req_tag(isect_req_tag),
        .isect_rsp_valid(isect_rsp_valid), .isect_rsp_ready(isect_rsp_ready),
        .isect_rsp_hit(isect_rsp_hit), .isect_rsp_u(isect_rsp_u),
        .isect_rsp_v(isect_rsp_v), .isect_rsp_t(isect_rsp_t),
        .isect_rsp_tag(isect_rsp_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
        .rsp_tri_idx(rsp_tri_idx), .rsp_t(rsp_t), .rsp_u(rsp_u), .rsp_v(rsp_v)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [287:0] verts_of(input logic [15:0] idx);
        return {9{16'hA5C3, idx}};
    endfunction
    function automatic logic [31:0] u_of(input logic [15:0] idx);
        return {16'h3E00, idx};
    endfunction
    function automatic logic [31:0] v_of(input logic [15:0] idx);
        return {16'h3D00, idx};
    endfunction

    // Triangle result tables used by the intersect model.
    logic        tri_hit [0:255];
    logic [31:0] tri_t   [0:255];

    typedef struct {
        logic [15:0] idx;
        int          due;
    } ent_t;
    ent_t mem_q[$];
    ent_t isect_q[$];

    typedef struct packed {
        logic        hit;
        logic [15:0] idx;
        logic [31:0] t;
        logic [31:0] u;
        logic [31:0] v;
    } exp_t;
    exp_t sb_q[$];

    logic        mem_en, isect_en, rand_stall;
    logic [15:0] exp_mem_idx, exp_fwd_idx;
    logic [95:0] cur_origin, cur_dir;
    logic [31:0] mdl_best_t;
    int          cyc = 0;
    int          mem_cnt, outstanding, max_out;

    // Environment: memory (latency 1) and intersect unit (latency 2).
    initial begin
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_verts = '0;
        isect_req_ready = 1'b0; isect_rsp_valid = 1'b0; isect_rsp_hit = 1'b0;
        isect_rsp_u = '0; isect_rsp_v = '0; isect_rsp_t = '0; isect_rsp_tag = '0;
        outstanding = 0;
        forever begin
            @(negedge clk);
            cyc++;
            mem_req_ready   = mem_en && (!rand_stall || ($urandom_range(0, 3) != 0));
            isect_req_ready = isect_en && (!rand_stall || ($urandom_range(0, 3) != 0));
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_verts = verts_of(mem_q[0].idx);
            end else begin
                mem_rsp_valid = 1'b0;
                mem_rsp_verts = '0;
            end
            if (isect_q.size() > 0 && isect_q[0].due <= cyc) begin
                isect_rsp_valid = 1'b1;
                isect_rsp_tag   = isect_q[0].idx;
                isect_rsp_hit   = tri_hit[isect_q[0].idx[7:0]];
                isect_rsp_t     = tri_t[isect_q[0].idx[7:0]];
                isect_rsp_u     = u_of(isect_q[0].idx);
                isect_rsp_v     = v_of(isect_q[0].idx);
            end else begin
                isect_rsp_valid = 1'b0;
                isect_rsp_hit   = 1'b0;
            end
            #1;
            if (reset) begin
                mem_q.delete();
                isect_q.delete();
                outstanding = 0;
            end else begin
                if (mem_req_valid && mem_req_ready) begin
                    check("mem_req_idx", {272'd0, mem_req_idx}, {272'd0, exp_mem_idx});
                    exp_mem_idx++;
                    mem_cnt++;
                    outstanding++;
                    mem_q.push_back('{idx: mem_req_idx, due: cyc + 1});
                end
                if (isect_req_valid && isect_req_ready && mem_q.size() > 0) begin
                    check("isect_tag", {272'd0, isect_req_tag}, {272'd0, exp_fwd_idx});
                    check("isect_verts", isect_req_verts, verts_of(mem_q[0].idx));
                    check("isect_origin", {192'd0, isect_req_origin}, {192'd0, cur_origin});
                    check("isect_dir", {192'd0, isect_req_dir}, {192'd0, cur_dir});
                    check("isect_tmax", {256'd0, isect_req_tmax}, {256'd0, mdl_best_t});
                    exp_fwd_idx++;
                    void'(mem_q.pop_front());
                    isect_q.push_back('{idx: isect_req_tag, due: cyc + 2});
                end
                if (isect_rsp_valid && isect_rsp_ready) begin
                    if (isect_rsp_hit && (isect_rsp_t < mdl_best_t)) mdl_best_t = isect_rsp_t;
                    void'(isect_q.pop_front());
                    outstanding--;
                end
                if (outstanding > max_out) max_out = outstanding;
            end
        end
    end

    task automatic load_tris(input logic [15:0] base, input logic [16:0] cnt,
                             input logic [7:0] mask, input logic [7:0][31:0] t);
        for (int i = 0; i < 8; i++) begin
            if (i < int'(cnt)) begin
                tri_hit[8'(base + 16'(i))] = mask[i];
                tri_t[8'(base + 16'(i))]   = t[i];
            end
        end
    endtask

    task automatic start_job(input logic [15:0] base, input logic [16:0] cnt,
                             input logic [31:0] tmax, input logic push,
                             input logic e_hit, input logic [15:0] e_idx, input logic [31:0] e_t);
        int n;
        exp_t e;
        @(negedge clk);
        exp_mem_idx = base;
        exp_fwd_idx = base;
        mdl_best_t  = tmax;
        mem_cnt     = 0;
        max_out     = 0;
        cur_origin  = {$urandom, $urandom, $urandom};
        cur_dir     = {$urandom, $urandom, $urandom};
        if (push) begin
            e.hit = e_hit;
            e.idx = e_idx;
            e.t   = e_t;
            e.u   = e_hit ? u_of(e_idx) : 32'd0;
            e.v   = e_hit ? v_of(e_idx) : 32'd0;
            sb_q.push_back(e);
        end
        req_valid = 1'b1; req_origin = cur_origin; req_dir = cur_dir;
        req_tmax = tmax; req_tri_base = base; req_tri_count = cnt;
        #1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!req_ready) begin
            n_checks++; n_fail++;
            $display("FAIL req_accept_timeout: req_ready stayed 0, expected 1");
        end
        @(negedge clk);
        req_valid = 1'b0;
        if (cnt == 17'd0) check("zero_cnt_rsp_valid", {287'd0, rsp_valid}, 288'd1);
        else              check("first_mem_req_valid", {287'd0, mem_req_valid}, 288'd1);
    endtask

    task automatic finish_job(input logic [16:0] cnt, input int hold);
        int   n;
        exp_t e;
        n = 0;
        while (!rsp_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            n_checks++; n_fail++;
            $display("FAIL rsp_timeout: rsp_valid stayed 0, expected 1");
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            return;
        end
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check("rsp_hold", {287'd0, rsp_valid}, 288'd1);
        end
        check("done_req_ready", {287'd0, req_ready}, 288'd0);
        check("mem_req_count", {256'd0, 32'(mem_cnt)}, {256'd0, 32'(cnt)});
        check("credit_bound", {287'd0, (max_out <= 4)}, 288'd1);
        if (sb_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_empty: got response, expected none");
        end else begin
            e = sb_q.pop_front();
            check("rsp_hit", {287'd0, rsp_hit}, {287'd0, e.hit});
            check("rsp_tri_idx", {272'd0, rsp_tri_idx}, {272'd0, e.idx});
            check("rsp_t", {256'd0, rsp_t}, {256'd0, e.t});
            check("rsp_u", {256'd0, rsp_u}, {256'd0, e.u});
            check("rsp_v", {256'd0, rsp_v}, {256'd0, e.v});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_release_valid", {287'd0, rsp_valid}, 288'd0);
        check("rsp_release_ready", {287'd0, req_ready}, 288'd1);
    endtask

    typedef struct packed {
        logic [15:0]      base;
        logic [16:0]      cnt;
        logic [31:0]      tmax;
        logic [7:0]       mask;
        logic [7:0][31:0] t;
        logic             stall;
        logic             e_hit;
        logic [15:0]      e_idx;
        logic [31:0]      e_t;
    } vec_t;

    function automatic vec_t mkvec(input logic [15:0] base, input logic [16:0] cnt,
                                   input logic [31:0] tmax, input logic [7:0] mask,
                                   input logic [7:0][31:0] t, input logic stall,
                                   input logic e_hit, input logic [15:0] e_idx,
                                   input logic [31:0] e_t);
        vec_t r;
        r.base = base; r.cnt = cnt; r.tmax = tmax; r.mask = mask; r.t = t;
        r.stall = stall; r.e_hit = e_hit; r.e_idx = e_idx; r.e_t = e_t;
        return r;
    endfunction

    vec_t vecs [0:7];

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_origin = '0; req_dir = '0;
        req_tmax = '0; req_tri_base = '0; req_tri_count = '0; rsp_ready = 1'b0;
        mem_en = 1'b1; isect_en = 1'b1; rand_stall = 1'b0;
        exp_mem_idx = '0; exp_fwd_idx = '0; mdl_best_t = '0;
        cur_origin = '0; cur_dir = '0; mem_cnt = 0; max_out = 0;
        for (int i = 0; i < 256; i++) begin
            tri_hit[i] = 1'b0;
            tri_t[i]   = 32'h0;
        end

        vecs[0] = mkvec(16'd7,   17'd1, 32'h42C80000, 8'h01,
                        {{7{32'h0}}, 32'h40000000}, 1'b0, 1'b1, 16'd7, 32'h40000000);
        vecs[1] = mkvec(16'd10,  17'd3, 32'h42C80000, 8'h07,
                        {{5{32'h0}}, 32'h40000000, 32'h3F800000, 32'h40A00000},
                        1'b0, 1'b1, 16'd11, 32'h3F800000);
        vecs[2] = mkvec(16'd4,   17'd2, 32'h42C80000, 8'h03,
                        {{6{32'h0}}, 32'h3F800000, 32'h3F800000}, 1'b0, 1'b1, 16'd4, 32'h3F800000);
        vecs[3] = mkvec(16'd20,  17'd3, 32'h42C80000, 8'h00,
                        {{5{32'h0}}, {3{32'h3F000000}}}, 1'b0, 1'b0, 16'd0, 32'h42C80000);
        vecs[4] = mkvec(16'd30,  17'd0, 32'h41200000, 8'h00,
                        {8{32'h0}}, 1'b0, 1'b0, 16'd0, 32'h41200000);
        vecs[5] = mkvec(16'd40,  17'd4, 32'h40400000, 8'b0000_1011,
                        {{4{32'h0}}, 32'h40000000, 32'h3F000000, 32'h40A00000, 32'h40800000},
                        1'b0, 1'b1, 16'd43, 32'h40000000);
        vecs[6] = mkvec(16'd100, 17'd8, 32'h42C80000, 8'b0011_0110,
                        {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                         32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000},
                        1'b1, 1'b1, 16'd105, 32'h40400000);
        vecs[7] = mkvec(16'd200, 17'd5, 32'h42C80000, 8'b0001_1101,
                        {{3{32'h0}}, 32'h3F800000, 32'h40000000, 32'h3F800000,
                         32'h3F800000, 32'h40400000},
                        1'b1, 1'b1, 16'd202, 32'h3F800000);

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_req_ready", {287'd0, req_ready}, 288'd1);
        check("rst_mem_req_valid", {287'd0, mem_req_valid}, 288'd0);
        check("rst_isect_req_valid", {287'd0, isect_req_valid}, 288'd0);
        check("rst_rsp_valid", {287'd0, rsp_valid}, 288'd0);
        check("rst_rsp_t", {256'd0, rsp_t}, 288'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            load_tris(vecs[i].base, vecs[i].cnt, vecs[i].mask, vecs[i].t);
            rand_stall = vecs[i].stall;
            start_job(vecs[i].base, vecs[i].cnt, vecs[i].tmax, 1'b1,
                      vecs[i].e_hit, vecs[i].e_idx, vecs[i].e_t);
            finish_job(vecs[i].cnt, (i == 1) ? 2 : 0);
        end
        rand_stall = 1'b0;

        // Credit limit: intersect never ready, so only four fetches may issue.
        load_tris(16'd50, 17'd8, 8'hFF, {8{32'h3F800000}});
        isect_en = 1'b0;
        start_job(16'd50, 17'd8, 32'h42C80000, 1'b1, 1'b1, 16'd50, 32'h3F800000);
        repeat (20) @(negedge clk);
        check("credit_mem_cnt", {256'd0, 32'(mem_cnt)}, {256'd0, 32'd4});
        check("credit_mem_valid", {287'd0, mem_req_valid}, 288'd0);
        isect_en = 1'b1;
        finish_job(17'd8, 0);
        check("credit_max_out", {256'd0, 32'(max_out)}, {256'd0, 32'd4});

        // Reset in the middle of a running job.
        isect_en = 1'b0;
        start_job(16'd60, 17'd8, 32'h42C80000, 1'b0, 1'b0, 16'd0, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        isect_en = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_req_ready", {287'd0, req_ready}, 288'd1);
        check("midrst_mem_req_valid", {287'd0, mem_req_valid}, 288'd0);
        check("midrst_isect_req_valid", {287'd0, isect_req_valid}, 288'd0);
        check("midrst_rsp_valid", {287'd0, rsp_valid}, 288'd0);

        // Normal operation resumes after the reset.
        load_tris(vecs[0].base, vecs[0].cnt, vecs[0].mask, vecs[0].t);
        start_job(vecs[0].base, vecs[0].cnt, vecs[0].tmax, 1'b1,
                  vecs[0].e_hit, vecs[0].e_idx, vecs[0].e_t);
        finish_job(vecs[0].cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit.
    initial begin
        #400000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

endmodule
